std_sdiv_pipe: RTL
==================

STD_SDIV_PIPE -- requirements
Module: std_sdiv_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, quotient and remainder width in bits, minimum 2.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port go  input  1  start/hold request, held high by the controller until done.
REQ-005 SHALL have port left  input  WIDTH  signed dividend, sampled on the start cycle.
REQ-006 SHALL have port right  input  WIDTH  signed divisor, sampled on the start cycle.
REQ-007 SHALL have port out_quotient  output  WIDTH  signed quotient, registered.
REQ-008 SHALL have port out_remainder  output  WIDTH  signed remainder, registered.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse, registered.

Function
REQ-010 SHALL implement a four-state FSM: IDLE, RUN, FIX and DONE.
REQ-011 In IDLE with go=1 at a rising edge, SHALL capture left and right, store |left| and |right| plus both sign bits, clear the partial remainder, load the iteration counter with WIDTH, and enter RUN.
REQ-012 In RUN, SHALL perform one restoring shift-subtract step per cycle on unsigned magnitudes, using a WIDTH+1-bit partial remainder, and SHALL decrement the counter each step.
REQ-013 After exactly WIDTH RUN cycles, SHALL enter FIX.
REQ-014 In FIX, SHALL negate the quotient if the operand signs differ, negate the remainder if left is negative, register both outputs, and enter DONE.
REQ-015 In DONE, SHALL assert done=1 for exactly that cycle, then return to IDLE unconditionally.
REQ-016 Latency SHALL be fixed: if go is first sampled high at edge 0, done SHALL be high in the cycle after edge WIDTH+2.
REQ-017 Results SHALL truncate toward zero, with remainder sign following the dividend (left = q*right + r, |r| < |right|).
REQ-018 Magnitude of the most negative value (-2^(WIDTH-1)) SHALL be computed in WIDTH bits as an unsigned value, with no overflow.
REQ-019 For left = -2^(WIDTH-1) and right = -1, SHALL output quotient -2^(WIDTH-1) (wrap) and remainder 0.
REQ-020 For right = 0, SHALL output quotient all-ones and remainder = left, with the same latency as any other operation.
REQ-021 If go falls while in RUN or FIX, SHALL abort to IDLE on the next edge, leave done low, and leave the outputs unchanged.
REQ-022 Changes on left or right after the start cycle SHALL have no effect on the operation in flight.
REQ-023 out_quotient and out_remainder SHALL hold their last values until the next FIX.
REQ-024 A go held high through DONE SHALL start a new operation from the IDLE cycle that follows.

Reset
REQ-025 reset_n=0 SHALL asynchronously force the FSM to IDLE and clear out_quotient, out_remainder, done, the counter and all datapath registers to 0.
REQ-026 Reset asserted mid-operation SHALL discard the operation, and no done pulse SHALL follow.
REQ-027 Reset release SHALL be synchronous to clk, with the first start possible at the first edge after release.

Configuration
REQ-028 With macro STD_SDIV_DIV0_FLAG_EN defined, SHALL add port div_by_zero  output  1, which is registered, set in FIX when the captured right is 0 (cleared otherwise), held like the outputs, and reset to 0.
REQ-029 Without STD_SDIV_DIV0_FLAG_EN, the port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-030 left=100, right=7, go held -> done in the cycle after edge 10, quotient 14, remainder 2, done high exactly one cycle.
REQ-031 Sign combinations -> -100/7 gives -14 r -2; 100/-7 gives -14 r 2; -100/-7 gives 14 r -2.
REQ-032 left=-128, right=-1 -> quotient -128 (0x80), remainder 0; left=-128, right=1 -> quotient -128, remainder 0.
REQ-033 left=5, right=0 -> quotient 0xFF, remainder 5, latency unchanged; with STD_SDIV_DIV0_FLAG_EN, div_by_zero=1.
REQ-034 go dropped at edge 4 -> no done, outputs keep prior values; reset_n pulsed low at edge 5 of a new operation -> outputs 0, no done, and a fresh 9/2 start gives 4 r 1.
REQ-035 Back-to-back run: go held through DONE, operands changed during RUN -> second result uses operands sampled at the second start edge only.

Source files
------------

// File: rtl/std_sdiv_pipe.sv
// -----------------------------------------------------------------------------
// std_sdiv_pipe -- iterative signed divider (restoring, one bit per cycle)
//
// Divides a signed dividend by a signed divisor using unsigned magnitudes and
// a sign fix-up at the end.  The quotient truncates toward zero.  The
// remainder takes the sign of the dividend.  Latency is fixed at WIDTH+3
// edges from the start edge to the done pulse, including division by zero.
//
// Parameters
//   WIDTH          operand / quotient / remainder width (>= 2), default 32
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset (release synchronous to clk)
//   go             start/hold request; dropping it mid-operation aborts
//   left           signed dividend, sampled on the start edge
//   right          signed divisor, sampled on the start edge
//   out_quotient   registered signed quotient, held until the next result
//   out_remainder  registered signed remainder, held until the next result
//   done           registered one-cycle completion pulse
//   div_by_zero    registered flag, 1 when the last result had right == 0
//                  (present only when STD_SDIV_DIV0_FLAG_EN is defined)
//
// Build option
//   STD_SDIV_DIV0_FLAG_EN  adds the div_by_zero output and its register.
// -----------------------------------------------------------------------------
module std_sdiv_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             done
`ifdef STD_SDIV_DIV0_FLAG_EN
    ,
    output logic             div_by_zero
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dvd;      // dividend magnitude, shifts out as quotient shifts in
    logic [WIDTH-1:0] dsr;      // divisor magnitude
    logic [WIDTH:0]   prem;     // partial remainder
    logic             neg_l;
    logic             neg_r;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic             div0;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Two's-complement magnitude in WIDTH bits.  The most negative value maps
    // to 2^(WIDTH-1), which is representable as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // One restoring step: bring in the next dividend bit, then subtract the
    // divisor if it fits.  The top bit of prem is always 0 between steps, so
    // shifting it out loses nothing.
    always_comb begin
        shifted = (prem << 1) | {{WIDTH{1'b0}}, dvd[WIDTH-1]};
        diff    = shifted - {1'b0, dsr};
        ge      = (shifted >= {1'b0, dsr});
    end

    // Sign fix-up.  A zero divisor always subtracts, which leaves an all-ones
    // quotient and |left| as the remainder.  The quotient is never negated in
    // that case, so the all-ones result does not depend on the dividend sign.
    always_comb begin
        div0  = (dsr == '0);
        q_fix = ((neg_l ^ neg_r) && !div0) ? -dvd : dvd;
        r_fix = neg_l ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register sees the values from before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            count         <= '0;
            dvd           <= '0;
            dsr           <= '0;
            prem          <= '0;
            neg_l         <= 1'b0;
            neg_r         <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
            done          <= 1'b0;
`ifdef STD_SDIV_DIV0_FLAG_EN
            div_by_zero   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        dvd   <= magnitude(left);
                        dsr   <= magnitude(right);
                        neg_l <= left[WIDTH-1];
                        neg_r <= right[WIDTH-1];
                        prem  <= '0;
                        count <= CW'(WIDTH);
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (!go) begin
                        state <= IDLE;
                    end else begin
                        prem  <= ge ? diff : shifted;
                        dvd   <= {dvd[WIDTH-2:0], ge};
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            state <= FIX;
                        end
                    end
                end

                FIX: begin
                    if (!go) begin
                        state <= IDLE;
                    end else begin
                        out_quotient  <= q_fix;
                        out_remainder <= r_fix;
`ifdef STD_SDIV_DIV0_FLAG_EN
                        div_by_zero   <= div0;
`endif
                        state         <= DONE;
                    end
                end

                DONE: begin
                    // The pulse is registered here, so it is visible in the
                    // IDLE cycle that follows.  A held go restarts from there.
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
